sst_engine: RTL and testbench
=============================

SST_ENGINE -- requirements
Module: sst_engine

Interface
REQ-001 SHALL have parameter M3_TIMEOUT, default 255: clk cycles allowed waiting for cpu_m3 per write.
REQ-002 SHALL have clk, input, 1: single clock; every register updates on its rising edge.
REQ-003 SHALL have map_rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have start_save / start_load, input, 1 each: single-cycle requests.
REQ-005 SHALL have cpu_m3, input, 1: CPU cycle qualifier; mapper register writes land only while it is high.
REQ-006 SHALL have map_idx, input, 8: index of the currently loaded mapper.
REQ-007 SHALL have sst_act, sst_we_reg, output, 1 each; sst_addr, output, 8; sst_dato, output, 8: the save-state bus driven to the mapper.
REQ-008 SHALL have sst_di, input, 8: mapper register readback, combinational on sst_addr.
REQ-009 SHALL have buf_addr, output, 7; buf_we, output, 1; buf_do, output, 8: snapshot RAM write port and address.
REQ-010 SHALL have buf_di, input, 8: snapshot RAM read data, one-cycle latency after buf_addr.
REQ-011 SHALL have busy, done, err, output, 1 each: status; done and err are single-cycle pulses.

Function
REQ-012 SHALL use the states IDLE, SV_ADDR, SV_CAP, LC_RD, LC_CMP, LD_RD, LD_WR, FIN.
REQ-013 SHALL leave IDLE only on a start pulse; if both pulses arrive together, save wins; pulses seen while busy are ignored.
REQ-014 SHALL assert sst_act and busy in every state except IDLE.
REQ-015 SHALL save as follows: SV_ADDR drives sst_addr=n; SV_CAP writes sst_di into buf[n] with buf_we high for one cycle; n runs 0..127; the save takes 256 cycles.
REQ-016 SHALL start a load with a check: LC_RD reads buf[127]; LC_CMP compares buf_di with sst_di at sst_addr=127 (the map_idx slot).
REQ-017 SHALL, on a check mismatch, go to FIN with err pulsed and perform no register writes.
REQ-018 SHALL, on a check match, for n=0..126: LD_RD puts n on buf_addr; LD_WR drives sst_addr=n, sst_dato=buf_di (latched) and sst_we_reg=1 until cpu_m3 is sampled high, then advances.
REQ-019 SHALL never write address 127 during a load.
REQ-020 SHALL keep sst_we_reg asserted only in LD_WR; multiple m3-high cycles at the same n are allowed (idempotent).
REQ-021 SHALL count clk cycles in LD_WR with an 8-bit counter; reaching M3_TIMEOUT without m3 -> err pulse, abort to FIN.
REQ-022 SHALL let FIN last one cycle: done pulses (and err, if set), then IDLE; sst_act drops in IDLE.
REQ-023 SHALL wrap the address counter 7 bits wide; the terminal compare is against 127 (save) or 126 (load), with no overflow beyond it.
REQ-024 SHALL hold sst_addr, sst_dato and buf_do stable in every cycle that sst_we_reg or buf_we is high.

Reset
REQ-025 SHALL, while map_rst is high, go to IDLE and drive all outputs 0 (sst_addr=0, buf_addr=0).
REQ-026 SHALL, if map_rst arrives mid-operation, abort at the next edge with no done or err pulse; a partial snapshot or partial register restore is accepted.
REQ-027 SHALL ignore a start pulse in the same cycle as map_rst.

Structure
REQ-028 SHALL take the state enum, SST_MAP_IDX_ADDR=127, SST_LAST_LOAD=126 and the default M3_TIMEOUT from shared package sst_pkg.
REQ-029 SHALL place the m3 wait/timeout counter in one sub-module, sst_m3_wait; all else stays flat.

Verification
REQ-030 SHALL check save: mapper model regs 0..7=8'h10..8'h17, reg8=8'h40, map_idx=4; start_save -> buf[0..7]=10..17, buf[8]=40, buf[127]=04, done at cycle 256, err=0.
REQ-031 SHALL check load with m3 high every 12th clk: buf from REQ-030, model cleared -> model regs restored, 127 writes, done, err=0.
REQ-032 SHALL check the load check: buf[127]=05, map_idx=4 -> err+done within 3 cycles, sst_we_reg never high.
REQ-033 SHALL check timeout: cpu_m3 held 0 during a load -> err at cycle 255 of the first LD_WR, model unchanged.
REQ-034 SHALL check start collision: start_save and start_load in the same cycle -> save runs; a start_load 10 cycles later is ignored.
REQ-035 SHALL check reset mid-load: map_rst at n=40 -> next cycle sst_act=0, busy=0, no done; a following save completes normally.

Source files
------------

// File: rtl/sst_pkg.sv
// Shared definitions for the save-state engine: FSM states, fixed mapper
// addresses and the default m3 wait budget.
package sst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SV_ADDR,
        SV_CAP,
        LC_RD,
        LC_CMP,
        LD_RD,
        LD_WR,
        FIN
    } sst_state_e;

    // Mapper slot holding the mapper index; also the last address saved
    localparam logic [6:0] SST_MAP_IDX_ADDR = 7'd127;
    // Last register restored on a load (the index slot is never written)
    localparam logic [6:0] SST_LAST_LOAD    = 7'd126;
    // Default clk cycles allowed for cpu_m3 per register write
    localparam int         SST_M3_TIMEOUT   = 255;

endpackage

// File: rtl/sst_m3_wait.sv
// Wait budget for cpu_m3 during a register write: an 8-bit down-counter
// armed before each write and flagging expiry on its terminal count.
module sst_m3_wait
    import sst_pkg::*;
#(
    parameter int M3_TIMEOUT = SST_M3_TIMEOUT
) (
    input  logic clk,
    input  logic map_rst,
    input  logic arm,
    input  logic run,
    input  logic cpu_m3,
    output logic expired
);

    // The count is loaded with TC while arming, so the terminal count of zero
    // lands in the M3_TIMEOUT-th cycle of the wait.
    localparam logic [7:0] TC = 8'(M3_TIMEOUT - 1);

    logic [7:0] cnt;

    // Reload on arm, count down once per waiting cycle, hold at zero
    always_ff @(posedge clk) begin
        if (map_rst) begin
            cnt <= '0;
        end else if (arm) begin
            cnt <= TC;
        end else if (run && (cnt != 8'd0)) begin
            cnt <= cnt - 8'd1;
        end
    end

    // m3 arriving in the last allowed cycle still wins over the timeout
    assign expired = run && !cpu_m3 && (cnt == 8'd0);

endmodule

// File: rtl/sst_engine.sv
// Save-state engine: snapshots mapper registers 0..127 into a 128-byte
// buffer, and restores registers 0..126 after checking that the snapshot
// belongs to the currently loaded mapper.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start_save / start_load
// SV_ADDR | present register n on sst_addr, capture its readback
// SV_CAP  | write captured value into buf[n]
// LC_RD   | read buf[127] (saved mapper index)
// LC_CMP  | compare saved index with live mapper index
// LD_RD   | buf[n] data available, latch it for the write
// LD_WR   | drive register write of n until cpu_m3 or timeout
// FIN     | one-cycle done (and err) pulse
module sst_engine
    import sst_pkg::*;
#(
    parameter int M3_TIMEOUT = SST_M3_TIMEOUT
) (
    input  logic       clk,
    input  logic       map_rst,
    input  logic       start_save,
    input  logic       start_load,
    input  logic       cpu_m3,
    input  logic [7:0] map_idx,
    output logic       sst_act,
    output logic       sst_we_reg,
    output logic [7:0] sst_addr,
    output logic [7:0] sst_dato,
    input  logic [7:0] sst_di,
    output logic [6:0] buf_addr,
    output logic       buf_we,
    output logic [7:0] buf_do,
    input  logic [7:0] buf_di,
    output logic       busy,
    output logic       done,
    output logic       err
);

    sst_state_e state;
    logic [6:0] n;
    logic [6:0] n_inc;
    logic       m3_expired;

    assign n_inc = n + 7'd1;

    sst_m3_wait #(
        .M3_TIMEOUT (M3_TIMEOUT)
    ) u_m3_wait (
        .clk     (clk),
        .map_rst (map_rst),
        .arm     (state == LD_RD),
        .run     (state == LD_WR),
        .cpu_m3  (cpu_m3),
        .expired (m3_expired)
    );

    // Sequencer with all outputs registered alongside the state.
    // The buffer read address is always one step ahead of the state that
    // consumes it: buf_di then already holds the wanted byte in LC_CMP and
    // LD_RD, so the write data can be latched before sst_we_reg rises.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            state      <= IDLE;
            n          <= '0;
            sst_act    <= 1'b0;
            busy       <= 1'b0;
            sst_we_reg <= 1'b0;
            sst_addr   <= '0;
            sst_dato   <= '0;
            buf_addr   <= '0;
            buf_we     <= 1'b0;
            buf_do     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_save) begin
                        state    <= SV_ADDR;
                        n        <= '0;
                        sst_addr <= '0;
                        sst_act  <= 1'b1;
                        busy     <= 1'b1;
                    end else if (start_load) begin
                        state    <= LC_RD;
                        buf_addr <= SST_MAP_IDX_ADDR;
                        sst_act  <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                SV_ADDR: begin
                    state    <= SV_CAP;
                    buf_addr <= n;
                    buf_do   <= sst_di;
                    buf_we   <= 1'b1;
                end
                SV_CAP: begin
                    buf_we <= 1'b0;
                    if (n == SST_MAP_IDX_ADDR) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state    <= SV_ADDR;
                        n        <= n_inc;
                        sst_addr <= {1'b0, n_inc};
                    end
                end
                LC_RD: begin
                    state    <= LC_CMP;
                    sst_addr <= {1'b0, SST_MAP_IDX_ADDR};
                    buf_addr <= '0;
                end
                LC_CMP: begin
                    if (buf_di != sst_di) begin
                        state <= FIN;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        state <= LD_RD;
                        n     <= '0;
                    end
                end
                LD_RD: begin
                    state      <= LD_WR;
                    sst_addr   <= {1'b0, n};
                    sst_dato   <= buf_di;
                    sst_we_reg <= 1'b1;
                    buf_addr   <= n_inc;
                end
                LD_WR: begin
                    if (cpu_m3) begin
                        sst_we_reg <= 1'b0;
                        if (n == SST_LAST_LOAD) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= LD_RD;
                            n     <= n_inc;
                        end
                    end else if (m3_expired) begin
                        sst_we_reg <= 1'b0;
                        state      <= FIN;
                        done       <= 1'b1;
                        err        <= 1'b1;
                    end
                end
                FIN: begin
                    state    <= IDLE;
                    n        <= '0;
                    sst_act  <= 1'b0;
                    busy     <= 1'b0;
                    sst_addr <= '0;
                    buf_addr <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sst_engine.sv
// Bench for sst_engine: behavioural mapper register file and snapshot RAM
// around the engine, with expected snapshot/restore contents derived from
// the register values the bench itself wrote.
module tb_sst_engine;

    logic       clk = 1'b0;
    logic       map_rst;
    logic       start_save;
    logic       start_load;
    logic       cpu_m3 = 1'b0;
    logic [7:0] map_idx;
    logic       sst_act;
    logic       sst_we_reg;
    logic [7:0] sst_addr;
    logic [7:0] sst_dato;
    logic [7:0] sst_di;
    logic [6:0] buf_addr;
    logic       buf_we;
    logic [7:0] buf_do;
    logic [7:0] buf_di;
    logic       busy;
    logic       done;
    logic       err;

    logic [7:0] map_regs [0:127];
    logic [7:0] mem      [0:127];
    logic [7:0] exp_snap [0:127];
    logic [7:0] keep     [0:127];

    int n_checks = 0;
    int n_fail   = 0;
    int wr_count = 0;
    int wr127_count = 0;
    int we_cycles = 0;
    int done_count = 0;
    int m3_mode = 0;
    int tick = 0;

    always #5 clk = ~clk;

    sst_engine #(
        .M3_TIMEOUT (255)
    ) dut (
        .clk        (clk),
        .map_rst    (map_rst),
        .start_save (start_save),
        .start_load (start_load),
        .cpu_m3     (cpu_m3),
        .map_idx    (map_idx),
        .sst_act    (sst_act),
        .sst_we_reg (sst_we_reg),
        .sst_addr   (sst_addr),
        .sst_dato   (sst_dato),
        .sst_di     (sst_di),
        .buf_addr   (buf_addr),
        .buf_we     (buf_we),
        .buf_do     (buf_do),
        .buf_di     (buf_di),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Mapper: slot 127 reads back the mapper index, the rest are registers
    assign sst_di = (sst_addr == 8'd127) ? map_idx : map_regs[sst_addr[6:0]];

    // Mapper register writes land only when cpu_m3 qualifies the cycle
    always @(posedge clk) begin
        if (sst_we_reg && cpu_m3) begin
            map_regs[sst_addr[6:0]] = sst_dato;
            wr_count++;
            if (sst_addr == 8'd127) wr127_count++;
        end
    end

    // Snapshot RAM, read-first, one cycle of read latency
    always @(posedge clk) begin
        buf_di <= mem[buf_addr];
        if (buf_we) mem[buf_addr] = buf_do;
    end

    // cpu_m3 pattern generator
    always @(negedge clk) begin
        tick++;
        case (m3_mode)
            1:       cpu_m3 = ((tick % 12) == 0);
            2:       cpu_m3 = ($urandom_range(0, 2) == 0);
            default: cpu_m3 = 1'b0;
        endcase
    end

    // Status observers
    always @(negedge clk) begin
        if (sst_we_reg) we_cycles++;
        if (done) done_count++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    task automatic pulse(input bit s, input bit l);
        @(negedge clk);
        start_save = s;
        start_load = l;
        @(negedge clk);
        start_save = 1'b0;
        start_load = 1'b0;
    endtask

    // cyc = clock edges after the start was sampled until done is seen
    task automatic wait_done(input int limit, input int inject_at, output int cyc, output bit got_err);
        bit seen;
        seen    = 1'b0;
        cyc     = 0;
        got_err = 1'b0;
        while (!seen && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (cyc == inject_at) start_load = 1'b1;
            else if (cyc == inject_at + 1) start_load = 1'b0;
            if (done) begin
                seen    = 1'b1;
                got_err = err;
            end
        end
        chk("done_seen", seen, 1'b1);
    endtask

    task automatic setup_regs(input bit fixed);
        for (int i = 0; i < 127; i++) map_regs[i] = 8'($urandom);
        map_regs[127] = 8'h00;
        if (fixed) begin
            for (int i = 0; i < 8; i++) map_regs[i] = 8'h10 + 8'(i);
            map_regs[8] = 8'h40;
        end
        for (int i = 0; i < 127; i++) exp_snap[i] = map_regs[i];
        exp_snap[127] = map_idx;
    endtask

    task automatic check_snap(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== exp_snap[i]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic check_restored(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 127; i++) if (map_regs[i] !== exp_snap[i]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic run_save(input string tag);
        int  cyc;
        bit  e;
        pulse(1'b1, 1'b0);
        chk({tag, "_busy"}, {sst_act, busy}, 2'b11);
        wait_done(400, -1, cyc, e);
        chk({tag, "_cycles"}, cyc, 256);
        chk({tag, "_err"}, e, 1'b0);
        check_snap({tag, "_snapshot"});
    endtask

    task automatic run_load(input string tag, input int mode);
        int cyc;
        bit e;
        for (int i = 0; i < 127; i++) map_regs[i] = 8'h00;
        wr_count    = 0;
        wr127_count = 0;
        m3_mode     = mode;
        pulse(1'b0, 1'b1);
        wait_done(4000, -1, cyc, e);
        m3_mode = 0;
        chk({tag, "_err"}, e, 1'b0);
        chk({tag, "_writes"}, wr_count, 127);
        chk({tag, "_wr127"}, wr127_count, 0);
        check_restored({tag, "_restored"});
    endtask

    initial begin
        int  cyc;
        bit  e;
        bit  found;
        int  dc0;
        int  bad;

        map_rst    = 1'b1;
        start_save = 1'b0;
        start_load = 1'b0;
        map_idx    = 8'd4;
        for (int i = 0; i < 128; i++) begin
            map_regs[i] = 8'h00;
            mem[i]      = 8'h00;
        end
        repeat (3) @(negedge clk);

        // Reset state, with a start pulse that must be ignored under reset
        start_save = 1'b1;
        @(negedge clk);
        start_save = 1'b0;
        chk("rst_act_busy", {sst_act, busy}, 2'b00);
        chk("rst_sst_addr", sst_addr, 8'd0);
        chk("rst_buf_addr", buf_addr, 7'd0);
        chk("rst_pulses", {done, err}, 2'b00);
        chk("rst_we", {sst_we_reg, buf_we}, 2'b00);
        map_rst = 1'b0;
        @(negedge clk);
        chk("start_in_rst_ignored", busy, 1'b0);

        // Save with the fixed register pattern
        setup_regs(1'b1);
        run_save("save_fixed");
        chk("save_buf0", mem[0], 8'h10);
        chk("save_buf7", mem[7], 8'h17);
        chk("save_buf8", mem[8], 8'h40);
        chk("save_buf127", mem[127], 8'h04);

        // Load with m3 every 12th clock
        run_load("load_m3_12", 1);

        // Randomized save/load round trip with random m3
        map_idx = 8'($urandom);
        setup_regs(1'b0);
        run_save("save_rand");
        run_load("load_m3_rand", 2);

        // Snapshot belongs to another mapper
        map_idx   = 8'd4;
        mem[127]  = 8'd5;
        we_cycles = 0;
        wr_count  = 0;
        pulse(1'b0, 1'b1);
        wait_done(10, -1, cyc, e);
        chk("idx_mismatch_in3", (cyc >= 1 && cyc <= 3), 1'b1);
        chk("idx_mismatch_err", e, 1'b1);
        chk("idx_mismatch_no_we", we_cycles, 0);
        chk("idx_mismatch_no_wr", wr_count, 0);

        // cpu_m3 never arrives
        mem[127] = 8'd4;
        for (int i = 0; i < 128; i++) keep[i] = map_regs[i];
        we_cycles = 0;
        wr_count  = 0;
        m3_mode   = 0;
        pulse(1'b0, 1'b1);
        wait_done(600, -1, cyc, e);
        chk("timeout_err", e, 1'b1);
        chk("timeout_we_cycles", we_cycles, 255);
        chk("timeout_no_wr", wr_count, 0);
        bad = 0;
        for (int i = 0; i < 128; i++) if (map_regs[i] !== keep[i]) bad++;
        chk("timeout_model_same", bad, 0);

        // Simultaneous starts: save wins, a later load pulse is ignored
        setup_regs(1'b0);
        we_cycles = 0;
        pulse(1'b1, 1'b1);
        wait_done(400, 10, cyc, e);
        chk("collide_cycles", cyc, 256);
        chk("collide_err", e, 1'b0);
        chk("collide_no_we", we_cycles, 0);
        check_snap("collide_snapshot");
        repeat (5) @(negedge clk);
        chk("collide_idle_after", busy, 1'b0);

        // Reset in the middle of a load
        m3_mode = 1;
        pulse(1'b0, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            if (sst_we_reg && sst_addr == 8'd40) found = 1'b1;
            else @(negedge clk);
        end
        chk("reached_n40", found, 1'b1);
        map_rst = 1'b1;
        dc0 = done_count;
        @(negedge clk);
        chk("midrst_act_busy", {sst_act, busy}, 2'b00);
        chk("midrst_pulses", {done, err, sst_we_reg}, 3'b000);
        map_rst = 1'b0;
        m3_mode = 0;
        repeat (20) @(negedge clk);
        chk("midrst_no_done", done_count - dc0, 0);
        setup_regs(1'b0);
        run_save("save_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
